adder_accum: RTL and testbench
==============================

// Module: adder_accum
// PURPOSE
//  Sequential multi-operand adder: accepts operands_p operands of width_p bits one per
//  handshake, accumulates them into a full-precision sum and presents the result on a
//  valid/ready output port. Sits between an operand producer and a result consumer.
//  Successor to the three-input combinational adder: operand count is a parameter and
//  the sum width is sized so it never overflows.
// PARAMETERS
//  width_p     4  operand width in bits (>=1)
//  operands_p  3  operands per transaction (>=2)
//  sum_width_p (derived, localparam) width_p + $clog2(operands_p)
// PORTS
//  clk_i     in   1                       single clock, all state on rising edge
//  reset_ni  in   1                       asynchronous, active-low reset
//  valid_i   in   1                       operand valid
//  ready_o   out  1                       block can accept an operand
//  data_i    in   width_p                 operand, unsigned
//  sub_i     in   1                       subtract this operand (ADDER_ACCUM_SUB_EN only)
//  count_o   out  $clog2(operands_p+1)    operands accepted in the current transaction
//  valid_o   out  1                       sum_o holds a completed result
//  ready_i   in   1                       consumer accepts the result
//  sum_o     out  sum_width_p             accumulated sum
// BEHAVIOUR
//  - Reset (reset_ni=0, async assert, sync deassert by the system):
//    state=ACCUM, acc=0, count=0; outputs sum_o=0, count_o=0, valid_o=0, ready_o=1.
//  - FSM with two states.
//    - ACCUM: ready_o=1, valid_o=0. An operand is accepted on a cycle with valid_i&&ready_o.
//      - First accept (count==0): acc <= zext(data_i).
//      - Every later accept: acc <= acc + zext(data_i).
//      - count increments on each accept.
//      - On the operands_p-th accept: state <= DONE and count <= 0.
//    - DONE: ready_o=0, valid_o=1. valid_i is ignored.
//      - On valid_o&&ready_i: state <= ACCUM. ready_o is 1 again on the following cycle.
//  - Latency: valid_o rises on the cycle after the last operand is accepted.
//  - Throughput: at most one result per operands_p+1 cycles. Input and output never overlap.
//  - sum_o is a direct register output (acc). It is meaningful only while valid_o=1.
//    It holds stable under backpressure (valid_o=1, ready_i=0) for any number of cycles.
//  - Cycles where valid_i=0 are bubbles: no state change, count_o unchanged.
//  - Arithmetic is modulo 2^sum_width_p. Unsigned-only mode cannot overflow.
//  - Reset mid-transaction: the partial sum and count are discarded.
//    The next accept starts a fresh transaction.
//  - ready_o and valid_o are decoded from the state register only.
//    They have no combinational path from valid_i or ready_i.
// CONFIGURATION
//  - ADDER_ACCUM_SUB_EN defined:
//    - sub_i port exists and is sampled with the operand.
//    - sub_i=1 contributes -zext(data_i); on the first operand, acc <= -zext(data_i).
//    - sum_o is read as two's complement. Out-of-range results wrap modulo 2^sum_width_p.
//  - ADDER_ACCUM_SUB_EN undefined: the sub_i port is absent and every operand is added.
// STRUCTURE
//  - Package adder_pkg holds:
//    - typedef enum logic {ACCUM, DONE} accum_state_e;
//    - function sum_width(width, operands), used for sum_width_p.
//  - Sub-module adder_accum_ctrl: FSM plus operand counter.
//    - Outputs: ready_o, valid_o, count_o, first_o, last_o.
//  - The top level holds the acc register and the add/subtract datapath.
// TESTING (width_p=4, operands_p=3, sum_width_p=6)
//  1 Reset: hold reset_ni=0 -> sum_o=0, count_o=0, valid_o=0, ready_o=1.
//    Assert reset_ni=0 after 2 accepts, release, then send 2,2,2 -> sum_o=6 (not stale).
//  2 Back-to-back 15,15,15 with ready_i=1 -> valid_o=1 on cycle 4, sum_o=45 (6'b101101).
//    Then ready_o=1 on cycle 5.
//  3 After test 2, hold ready_i=0 for 5 cycles with valid_i=1 -> sum_o stays 45,
//    valid_o stays 1, ready_o=0, count_o=0, no operand consumed.
//  4 Bubbles: 1,-,2,-,-,3 -> count_o steps 1,1,2,2,2,0; sum_o=6 one cycle after the 3.
//  5 ADDER_ACCUM_SUB_EN:
//    - 5, 7(sub), 3 -> sum_o=6'b000001.
//    - 0, 7(sub), 0 -> sum_o=6'b111001 (-7).
//  6 Random: 1000 transactions with random valid_i/ready_i.
//    A scoreboard compares against a behavioural sum.
//    Under `ifdef FORMAL, a concurrent assertion checks:
//    valid_o && !ready_i |=> $stable(sum_o) && valid_o.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and sum-width helper for the accumulating adder
package adder_pkg;
  typedef enum logic {ACCUM, DONE} accum_state_e;
  function automatic int sum_width(int width, int operands);
    return width + $clog2(operands);
  endfunction
endpackage

// File: rtl/adder_accum_ctrl.sv
// adder_accum_ctrl: ACCUM/DONE handshake FSM plus per-transaction operand counter
//   clk_i, reset_ni : clock, async active-low reset
//   valid_i/ready_o : operand handshake; ready_o decoded from state only
//   valid_o/ready_i : result handshake; valid_o decoded from state only
//   count_o         : operands accepted so far in this transaction
//   first_o, last_o : next accepted operand is the first / the last of the transaction
module adder_accum_ctrl
  import adder_pkg::*;
#(
  parameter  int operands_p = 3,
  localparam int cw = $clog2(operands_p + 1)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          valid_i,
  input  logic          ready_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [cw-1:0] count_o,
  output logic          first_o,
  output logic          last_o
);
  localparam logic [cw-1:0] last_c = cw'(operands_p - 1);
  accum_state_e state_q, state_d;
  logic [cw-1:0] count_q, count_d;
  logic accept;
  always_comb begin
    ready_o = state_q == ACCUM;
    valid_o = state_q == DONE;
    first_o = count_q == '0;
    last_o  = count_q == last_c;
    accept  = valid_i && ready_o;
    state_d = ready_o ? (accept && last_o ? DONE : ACCUM) : (ready_i ? ACCUM : DONE);
    count_d = accept ? (last_o ? '0 : count_q + 1'b1) : count_q;
    count_o = count_q;
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= ACCUM;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
endmodule

// File: rtl/adder_accum.sv
// adder_accum: sequential multi-operand adder, operands_p operands in, one full-precision sum out
//   clk_i, reset_ni : clock, async active-low reset
//   valid_i/ready_o : operand handshake, data_i unsigned operand
//   sub_i           : negate this operand (only with ADDER_ACCUM_SUB_EN defined)
//   valid_o/ready_i : result handshake, sum_o is the registered accumulator
//   count_o         : operands accepted in the current transaction
module adder_accum
  import adder_pkg::*;
#(
  parameter  int width_p     = 4,
  parameter  int operands_p  = 3,
  localparam int sum_width_p = sum_width(width_p, operands_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [width_p-1:0]                data_i,
`ifdef ADDER_ACCUM_SUB_EN
  input  logic                              sub_i,
`endif
  output logic [$clog2(operands_p+1)-1:0]   count_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [sum_width_p-1:0]            sum_o
);
  logic [sum_width_p-1:0] acc_q, acc_d, opnd;
  logic first, unused_last;
  adder_accum_ctrl #(.operands_p(operands_p)) u_ctrl (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .valid_i (valid_i),
    .ready_i (ready_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .count_o (count_o),
    .first_o (first),
    .last_o  (unused_last)
  );
  always_comb begin
`ifdef ADDER_ACCUM_SUB_EN
    opnd  = sub_i ? -sum_width_p'(data_i) : sum_width_p'(data_i);
`else
    opnd  = sum_width_p'(data_i);
`endif
    // the first operand overwrites, so a stale sum never leaks into a new transaction
    acc_d = valid_i && ready_o ? (first ? opnd : acc_q + opnd) : acc_q;
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) acc_q <= '0;
    else acc_q <= acc_d;
  assign sum_o = acc_q;
`ifdef FORMAL
  hold_a: assert property (@(posedge clk_i) disable iff (!reset_ni)
    valid_o && !ready_i |=> $stable(sum_o) && valid_o);
`endif
endmodule

// File: tb/tb_adder_accum.sv
// tb_adder_accum: vector table, corner sequences and randomized scoreboard for adder_accum
module tb_adder_accum;
  localparam int W = 4, N = 3, SW = 6, CW = 2;
  logic clk_i = 0, reset_ni = 0, valid_i = 0, ready_i = 0, sub_i = 0;
  logic [W-1:0] data_i = '0;
  logic ready_o, valid_o;
  logic [CW-1:0] count_o;
  logic [SW-1:0] sum_o;
  int total = 0, bad = 0;
  typedef struct {
    logic v; logic [W-1:0] d; logic s; logic r;
    int er; int ev; int ec; int es;
  } vec_t;
  vec_t tbl[20];
  always #5 clk_i = ~clk_i;
  adder_accum #(.width_p(W), .operands_p(N)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i),
`ifdef ADDER_ACCUM_SUB_EN
    .sub_i(sub_i),
`endif
    .count_o(count_o), .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o)
  );
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask
  task automatic chk_out(string tag, int er, int ev, int ec, int es);
    chk({tag, ".ready"}, int'(ready_o), er);
    chk({tag, ".valid"}, int'(valid_o), ev);
    chk({tag, ".count"}, int'(count_o), ec);
    chk({tag, ".sum"}, int'(sum_o), es);
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(logic v, logic [W-1:0] d, logic s, logic r);
    valid_i = v; data_i = d; sub_i = s; ready_i = r;
  endtask
  initial begin
    // back-to-back 15s, then backpressure with valid_i held, then bubbles
    tbl[0]  = '{1, 15, 0, 1, 1, 0, 1, 15};
    tbl[1]  = '{1, 15, 0, 1, 1, 0, 2, 30};
    tbl[2]  = '{1, 15, 0, 1, 0, 1, 0, 45};
    tbl[3]  = '{0, 0,  0, 1, 1, 0, 0, 45};
    tbl[4]  = '{1, 15, 0, 0, 1, 0, 1, 15};
    tbl[5]  = '{1, 15, 0, 0, 1, 0, 2, 30};
    tbl[6]  = '{1, 15, 0, 0, 0, 1, 0, 45};
    tbl[7]  = '{1, 3,  0, 0, 0, 1, 0, 45};
    tbl[8]  = '{1, 3,  0, 0, 0, 1, 0, 45};
    tbl[9]  = '{1, 3,  0, 0, 0, 1, 0, 45};
    tbl[10] = '{1, 3,  0, 0, 0, 1, 0, 45};
    tbl[11] = '{1, 3,  0, 0, 0, 1, 0, 45};
    tbl[12] = '{0, 0,  0, 1, 1, 0, 0, 45};
    tbl[13] = '{1, 1,  0, 0, 1, 0, 1, 1};
    tbl[14] = '{0, 0,  0, 0, 1, 0, 1, 1};
    tbl[15] = '{1, 2,  0, 0, 1, 0, 2, 3};
    tbl[16] = '{0, 0,  0, 0, 1, 0, 2, 3};
    tbl[17] = '{0, 0,  0, 0, 1, 0, 2, 3};
    tbl[18] = '{1, 3,  0, 0, 0, 1, 0, 6};
    tbl[19] = '{0, 0,  0, 1, 1, 0, 0, 6};
    #2 chk_out("reset", 1, 0, 0, 0);
    tick;
    reset_ni = 1;
    drive(1, 5, 0, 0); tick;
    drive(1, 6, 0, 0); tick;
    chk("pre_reset.count", int'(count_o), 2);
    #2 reset_ni = 0;
    #1 chk_out("async_reset", 1, 0, 0, 0);
    drive(0, 0, 0, 0); tick;
    reset_ni = 1;
    for (int i = 0; i < 3; i++) begin drive(1, 2, 0, 0); tick; end
    chk_out("post_reset", 0, 1, 0, 6);
    drive(0, 0, 0, 1); tick;
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r);
      tick;
      chk_out($sformatf("vec%0d", i), tbl[i].er, tbl[i].ev, tbl[i].ec, tbl[i].es);
    end
`ifdef ADDER_ACCUM_SUB_EN
    drive(1, 5, 0, 0); tick;
    drive(1, 7, 1, 0); tick;
    drive(1, 3, 0, 0); tick;
    chk_out("sub_a", 0, 1, 0, 1);
    drive(0, 0, 0, 1); tick;
    drive(1, 0, 0, 0); tick;
    drive(1, 7, 1, 0); tick;
    drive(1, 0, 0, 0); tick;
    chk_out("sub_b", 0, 1, 0, 57);
    drive(0, 0, 0, 1); tick;
`endif
    begin
      int n = 0, acc = 0, exp_sum = 0, done = 0, cyc = 0;
      bit hold = 0;
      logic v, s, r;
      logic [W-1:0] d;
      while (done < 1000 && cyc < 30000) begin
        v = $urandom_range(0, 9) < 7;
        d = W'($urandom_range(0, 15));
`ifdef ADDER_ACCUM_SUB_EN
        s = $urandom_range(0, 1) == 1;
`else
        s = 0;
`endif
        r = $urandom_range(0, 9) < 6;
        drive(v, d, s, r);
        chk("rand.ready", int'(ready_o), int'(!hold));
        chk("rand.valid", int'(valid_o), int'(hold));
        chk("rand.count", int'(count_o), n);
        if (hold) chk("rand.sum", int'(sum_o), exp_sum);
        if (hold && r) begin
          hold = 0;
          done++;
        end else if (!hold && v) begin
          acc += s ? -int'(d) : int'(d);
          n++;
          if (n == N) begin
            hold = 1;
            exp_sum = acc & ((1 << SW) - 1);
            n = 0;
            acc = 0;
          end
        end
        tick;
        cyc++;
      end
      if (done < 1000) chk("rand.budget", done, 1000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
